tone_decoder: RTL and testbench
===============================

Name: tone_decoder

Overview:
- Receive-side counterpart of the speaker tone generator.
- Measures the period of an incoming square wave (a speaker-line signal at 40 MHz system clock) and classifies it against the 17-note table.
- Presents the result as an 8-bit {hight,mid,low} note code, with strobe/valid, and scans it onto the 4-digit 7-segment display via the team's seg7 decoder.
- Used for loopback self-test of the tone generator and as a pitch-input front end.

Parameters:
- STABLE, 3, consecutive equal classifications required before the note output changes (1..7).
- TIMEOUT, 200000, clk cycles without a rising edge before the input is declared silent.
- TOL_SHIFT, 6, acceptance window is nominal period >> TOL_SHIFT (1.56 % at default).

Ports:
- clk  in  1  system clock, 40 MHz.
- rst_n  in  1  synchronous active-low reset.
- tone_in  in  1  asynchronous square-wave input.
- note  out  8  {hight[1:0],mid[2:0],low[2:0]} one-hot-per-octave note code; 0 = silence/unknown.
- note_valid  out  1  high while note is nonzero.
- note_stb  out  1  one-cycle pulse whenever note changes value.
- period  out  18  last measured period in clk cycles.
- com  out  4  digit enables, active low.
- seg  out  7  segment pattern from seg7.

Behaviour:
- Clock and reset:
  - One clock domain; reset is synchronous and active-low (rst_n sampled on posedge clk).
  - Reset clears: sync flops, period counter, match count, candidate, state=IDLE, note=0, note_valid=0, note_stb=0, period=0, scan counter=0.
  - Reset mid-measurement discards the partial period. The first edge after reset produces no period.
- Input path:
  - 2-flop synchronizer on tone_in, then a registered previous value.
  - rise = sync2 & ~prev.
- Period measurement:
  - 18-bit counter; the counted value equals the exact number of clk cycles between consecutive rises.
  - Counter saturates at 2^18-1.
- FSM:
  - IDLE: counter held at 0. On rise -> MEAS, counter starts.
  - MEAS, on rise: latch period_r, restart the counter, issue a classify request.
  - MEAS, counter reaching TIMEOUT with no rise in that cycle: -> IDLE, candidate history cleared, note forced to 0 (note_stb pulses if note was nonzero).
  - A rise in the same cycle as TIMEOUT takes priority and is treated as a measured period.
- Classification (registered, one stage after period_r):
  - Candidate = the table code whose nominal N satisfies |period_r - N| <= N>>TOL_SHIFT; otherwise 0.
  - Nominal N in cycles equals 4*(65536-divisor):
    - low 1..7: 153200, 136060, 121216, 114616, 102044, 90912, 80976.
    - mid 1..7: 76484, 68148, 60704, 57312, 51024, 45460, 40488.
    - high 1..3: 38244, 34048, 30352.
  - Codes: low k = 00_000_k; mid k = 00_k_000; high k = k_000_000.
  - The windows are disjoint at the default TOL_SHIFT.
- Stability filter (one stage after candidate):
  - If candidate equals the previous candidate, match count increments (saturating at STABLE); otherwise match count = 1.
  - When match count reaches STABLE and candidate != note: note <= candidate and note_stb pulses for 1 cycle.
  - A stable run of candidate 0 silences the output.
- Latency: note and note_stb update exactly 4 clk edges after the edge that first samples tone_in high (sync1, sync2, period_r, candidate, note).
- note_valid = (note != 0), registered together with note.
- Display:
  - Free-running 15-bit scan counter; bits [14:13] select the digit.
  - 0: com=4'h7, digit={2'b0,hight}.
  - 1: com=4'hb, digit={1'b0,mid}.
  - 2: com=4'hd, digit={1'b0,low}.
  - 3: com=4'hf, blank.
  - seg = seg7(digit).

Test Plan:
- Reset: hold rst_n=0 for 3 clk with tone_in toggling -> note=0, note_valid=0, note_stb=0, period=0, com=4'h7.
- Mid do: square wave with period 76484 clk -> after the 4th rise (+4 clk), note=8'b00_001_000, note_valid=1, a single note_stb pulse, period=76484; no further note_stb while the tone is held.
- Tolerance: period 76484+1190 -> mid do accepted; period 76484+1300 -> candidate 0; after STABLE such periods, note=0 with note_stb.
- Note change: switch from 76484 to 60704 -> note holds 00_001_000 for 2 new periods, then becomes 8'b00_011_000 with one note_stb. Repeat for table extremes: 153200 -> 00_000_001, 30352 -> 11_000_000.
- Silence:
  - Stop toggling -> exactly TIMEOUT cycles after the last counted edge, note=0, note_valid=0, one note_stb.
  - A rise landing on the TIMEOUT cycle -> measured as a period (classified 0), no timeout.
- Mid-run reset: assert rst_n=0 for 1 cycle halfway through a period -> all outputs clear; the next rise only starts measurement, and the note reappears after STABLE+1 rises.

Source files
------------

// File: rtl/tone_decoder.sv
// Measures the period of a square-wave input, classifies it against the 17-note table and
// shows the {high,mid,low} note code on a scanned 4-digit 7-segment display.

module tone_decoder #(
  parameter int unsigned STABLE      = 3,
  parameter int unsigned TIMEOUT     = 200000,
  parameter int unsigned TOL_SHIFT   = 6,
  // Right-shift applied to the nominal periods; nonzero only for a scaled-down clock.
  parameter int unsigned SCALE_SHIFT = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tone_in,
  output logic [7:0]  note,
  output logic        note_valid,
  output logic        note_stb,
  output logic [17:0] period,
  output logic [3:0]  com,
  output logic [6:0]  seg
);

  localparam int unsigned NumNotes = 17;
  localparam int unsigned CntMax   = (1 << 18) - 1;

  localparam int unsigned NomPeriod [NumNotes] = '{
    153200, 136060, 121216, 114616, 102044, 90912, 80976,
    76484, 68148, 60704, 57312, 51024, 45460, 40488,
    38244, 34048, 30352
  };

  localparam logic [7:0] NoteCode [NumNotes] = '{
    8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07,
    8'h08, 8'h10, 8'h18, 8'h20, 8'h28, 8'h30, 8'h38,
    8'h40, 8'h80, 8'hc0
  };

  typedef enum logic [0:0] {StIdle, StMeas} state_e;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    unique case (d)
      4'h0: s = 7'h3f;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5b;
      4'h3: s = 7'h4f;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6d;
      4'h6: s = 7'h7d;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7f;
      4'h9: s = 7'h6f;
      4'ha: s = 7'h77;
      4'hb: s = 7'h7c;
      4'hc: s = 7'h39;
      4'hd: s = 7'h5e;
      4'he: s = 7'h79;
      4'hf: s = 7'h71;
    endcase
    return s;
  endfunction

  // Input synchronizer and edge detect
  logic sync1_q, sync2_q, prev_q;
  logic rise;

  assign rise = sync2_q & ~prev_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= tone_in;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  // Period measurement FSM
  state_e      state_q, state_d;
  logic [17:0] cnt_q, cnt_d;
  logic [17:0] period_q, period_d;
  logic        req_q, req_d;
  logic        timeout;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    period_d = period_q;
    req_d    = 1'b0;
    timeout  = 1'b0;
    case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (rise) begin
          state_d = StMeas;
          cnt_d   = 18'd1;
        end
      end
      StMeas: begin
        // A rise on the timeout cycle still counts as a measured period.
        if (rise) begin
          period_d = cnt_q;
          cnt_d    = 18'd1;
          req_d    = 1'b1;
        end else if (32'(cnt_q) >= TIMEOUT) begin
          timeout = 1'b1;
          state_d = StIdle;
          cnt_d   = '0;
        end else if (32'(cnt_q) != CntMax) begin
          cnt_d = cnt_q + 18'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      period_q <= '0;
      req_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      period_q <= period_d;
      req_q    <= req_d;
    end
  end

  // Classification: windows are disjoint, so the per-note hits can simply be OR-ed
  logic [NumNotes*8-1:0] masked;
  logic [7:0]            cand_d, cand_q;
  logic                  cand_vld_q;

  for (genvar g = 0; g < NumNotes; g++) begin : g_win
    localparam int unsigned Nom = NomPeriod[g] >> SCALE_SHIFT;
    localparam int unsigned Tol = Nom >> TOL_SHIFT;
    logic hit;
    assign hit = (32'(period_q) + Tol >= Nom) && (32'(period_q) <= Nom + Tol);
    assign masked[g*8 +: 8] = hit ? NoteCode[g] : 8'h00;
  end

  always_comb begin
    cand_d = '0;
    for (int i = 0; i < NumNotes; i++) begin
      cand_d = cand_d | masked[i*8 +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cand_q     <= '0;
      cand_vld_q <= 1'b0;
    end else begin
      cand_q     <= cand_d;
      cand_vld_q <= req_q;
    end
  end

  // Stability filter
  logic [7:0] last_q, last_d;
  logic [2:0] match_q, match_d;
  logic [7:0] note_q, note_d;
  logic       stb_q, stb_d;
  logic       valid_q;

  always_comb begin
    last_d  = last_q;
    match_d = match_q;
    note_d  = note_q;
    stb_d   = 1'b0;
    if (timeout) begin
      last_d  = '0;
      match_d = '0;
      note_d  = '0;
      stb_d   = (note_q != 8'h00);
    end else if (cand_vld_q) begin
      last_d = cand_q;
      if (cand_q == last_q) begin
        match_d = (match_q >= 3'(STABLE)) ? match_q : match_q + 3'd1;
      end else begin
        match_d = 3'd1;
      end
      if (match_d >= 3'(STABLE) && cand_q != note_q) begin
        note_d = cand_q;
        stb_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_q  <= '0;
      match_q <= '0;
      note_q  <= '0;
      stb_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      last_q  <= last_d;
      match_q <= match_d;
      note_q  <= note_d;
      stb_q   <= stb_d;
      valid_q <= (note_d != 8'h00);
    end
  end

  // Display scan
  logic [14:0] scan_q;
  logic [3:0]  digit;
  logic        blank;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      scan_q <= '0;
    end else begin
      scan_q <= scan_q + 15'd1;
    end
  end

  always_comb begin
    com   = 4'hf;
    digit = 4'h0;
    blank = 1'b1;
    unique case (scan_q[14:13])
      2'd0: begin
        com   = 4'h7;
        digit = {2'b00, note_q[7:6]};
        blank = 1'b0;
      end
      2'd1: begin
        com   = 4'hb;
        digit = {1'b0, note_q[5:3]};
        blank = 1'b0;
      end
      2'd2: begin
        com   = 4'hd;
        digit = {1'b0, note_q[2:0]};
        blank = 1'b0;
      end
      2'd3: begin
        com   = 4'hf;
        blank = 1'b1;
      end
    endcase
    seg = blank ? 7'h00 : seg7(digit);
  end

  assign note       = note_q;
  assign note_valid = valid_q;
  assign note_stb   = stb_q;
  assign period     = period_q;

endmodule

// File: tb/tb_tone_decoder.sv
// Directed bench for tone_decoder, run with the note table scaled down by 2^6 and a short
// timeout so that every scenario fits in a modest number of cycles.

module tb_tone_decoder;

  localparam int unsigned Stable  = 3;
  localparam int unsigned Timeout = 3000;
  localparam int unsigned TolSh   = 6;
  localparam int unsigned ScaleSh = 6;

  // Scaled nominal periods (N >> 6) and window edges (tolerance N >> 12)
  localparam int PDo    = 1195;  // mid 1, window 1177..1213
  localparam int PRe    = 948;   // mid 3
  localparam int PLow1  = 2393;  // low 1
  localparam int PHigh3 = 474;   // high 3
  localparam int PAcc   = 1213;
  localparam int PRej   = 1214;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tone_in = 1'b0;
  logic [7:0]  note;
  logic        note_valid;
  logic        note_stb;
  logic [17:0] period;
  logic [3:0]  com;
  logic [6:0]  seg;

  int tests = 0;
  int fails = 0;
  int stb_total = 0;

  tone_decoder #(
    .STABLE     (Stable),
    .TIMEOUT    (Timeout),
    .TOL_SHIFT  (TolSh),
    .SCALE_SHIFT(ScaleSh)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .tone_in   (tone_in),
    .note      (note),
    .note_valid(note_valid),
    .note_stb  (note_stb),
    .period    (period),
    .com       (com),
    .seg       (seg)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (note_stb === 1'b1) stb_total <= stb_total + 1;

  // One full input period starting with a rise at the current negedge.
  task automatic drive_period(input int p);
    tone_in = 1'b1;
    repeat (p / 2) @(negedge clk);
    tone_in = 1'b0;
    repeat (p - p / 2) @(negedge clk);
  endtask

  // Same as drive_period, capturing outputs just before and just after the 4th edge.
  task automatic rise_peek(input int p, output logic [7:0] n4, output logic [7:0] n5,
                           output logic s5, output logic v5, output logic [17:0] per5);
    tone_in = 1'b1;
    repeat (4) @(negedge clk);
    n4 = note;
    @(negedge clk);
    n5   = note;
    s5   = note_stb;
    v5   = note_valid;
    per5 = period;
    repeat (p / 2 - 5) @(negedge clk);
    tone_in = 1'b0;
    repeat (p - p / 2) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) begin
      @(negedge clk);
      tone_in = ~tone_in;
    end
    @(negedge clk);
    tests++; if (note !== 8'h00) begin fails++; $display("FAIL reset_note: got %h want 00", note); end
    tests++; if (note_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", note_valid); end
    tests++; if (note_stb !== 1'b0) begin fails++; $display("FAIL reset_stb: got %b want 0", note_stb); end
    tests++; if (period !== 18'd0) begin fails++; $display("FAIL reset_period: got %0d want 0", period); end
    tests++; if (com !== 4'h7) begin fails++; $display("FAIL reset_com: got %h want 7", com); end
    tests++; if (seg !== 7'h3f) begin fails++; $display("FAIL reset_seg: got %h want 3f", seg); end
    tone_in = 1'b0;
    rst_n   = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_mid_do();
    logic [7:0] n4, n5;
    logic s5, v5;
    logic [17:0] per5;
    int base;
    base = stb_total;
    repeat (3) drive_period(PDo);
    rise_peek(PDo, n4, n5, s5, v5, per5);
    tests++; if (n4 !== 8'h00) begin fails++; $display("FAIL do_early: got %h want 00", n4); end
    tests++; if (n5 !== 8'h08) begin fails++; $display("FAIL do_note: got %h want 08", n5); end
    tests++; if (s5 !== 1'b1) begin fails++; $display("FAIL do_stb: got %b want 1", s5); end
    tests++; if (v5 !== 1'b1) begin fails++; $display("FAIL do_valid: got %b want 1", v5); end
    tests++; if (per5 !== 18'(PDo)) begin fails++; $display("FAIL do_period: got %0d want %0d", per5, PDo); end
    repeat (2) drive_period(PDo);
    tests++; if (stb_total - base !== 1) begin fails++; $display("FAIL do_stb_count: got %0d want 1", stb_total - base); end
    tests++; if (note !== 8'h08) begin fails++; $display("FAIL do_hold: got %h want 08", note); end
  endtask

  task automatic test_display();
    logic [3:0] coms [3];
    logic [6:0] segs [3];
    coms = '{4'hb, 4'hd, 4'hf};
    segs = '{7'h06, 7'h3f, 7'h00};
    fork
      repeat (15) drive_period(PDo);
      begin
        for (int i = 0; i < 3; i++) begin
          int w;
          w = 0;
          while (com !== coms[i] && w < 20000) begin
            @(negedge clk);
            w++;
          end
          tests++;
          if (com !== coms[i] || seg !== segs[i]) begin
            fails++;
            $display("FAIL display_%0d: got com %h seg %h want com %h seg %h", i, com, seg,
                     coms[i], segs[i]);
          end
        end
      end
    join
  endtask

  task automatic test_tolerance();
    logic [7:0] n4, n5;
    logic s5, v5;
    logic [17:0] per5;
    int base;
    base = stb_total;
    repeat (3) drive_period(PAcc);
    drive_period(PRej);
    tests++; if (period !== 18'(PAcc)) begin fails++; $display("FAIL tol_period: got %0d want %0d", period, PAcc); end
    repeat (2) drive_period(PRej);
    tests++; if (stb_total - base !== 0) begin fails++; $display("FAIL tol_accept_stb: got %0d want 0", stb_total - base); end
    tests++; if (note !== 8'h08) begin fails++; $display("FAIL tol_accept: got %h want 08", note); end
    rise_peek(PDo, n4, n5, s5, v5, per5);
    tests++; if (n4 !== 8'h08) begin fails++; $display("FAIL tol_early: got %h want 08", n4); end
    tests++; if (n5 !== 8'h00) begin fails++; $display("FAIL tol_reject: got %h want 00", n5); end
    tests++; if (s5 !== 1'b1) begin fails++; $display("FAIL tol_stb: got %b want 1", s5); end
    tests++; if (v5 !== 1'b0) begin fails++; $display("FAIL tol_valid: got %b want 0", v5); end
    tests++; if (per5 !== 18'(PRej)) begin fails++; $display("FAIL tol_rej_period: got %0d want %0d", per5, PRej); end
  endtask

  task automatic test_note_change();
    logic [7:0] n4, n5;
    logic s5, v5;
    logic [17:0] per5;
    int base;
    base = stb_total;
    repeat (3) drive_period(PDo);
    tests++; if (note !== 8'h08) begin fails++; $display("FAIL chg_start: got %h want 08", note); end
    repeat (2) drive_period(PRe);
    rise_peek(PRe, n4, n5, s5, v5, per5);
    tests++; if (n5 !== 8'h08 || s5 !== 1'b0) begin fails++; $display("FAIL chg_hold: got %h/%b want 08/0", n5, s5); end
    rise_peek(PLow1, n4, n5, s5, v5, per5);
    tests++; if (n4 !== 8'h08) begin fails++; $display("FAIL chg_re_early: got %h want 08", n4); end
    tests++; if (n5 !== 8'h18 || s5 !== 1'b1) begin fails++; $display("FAIL chg_re: got %h/%b want 18/1", n5, s5); end
    tests++; if (per5 !== 18'(PRe)) begin fails++; $display("FAIL chg_re_period: got %0d want %0d", per5, PRe); end
    repeat (2) drive_period(PLow1);
    rise_peek(PHigh3, n4, n5, s5, v5, per5);
    tests++; if (n5 !== 8'h01 || s5 !== 1'b1) begin fails++; $display("FAIL chg_low1: got %h/%b want 01/1", n5, s5); end
    tests++; if (per5 !== 18'(PLow1)) begin fails++; $display("FAIL chg_low1_period: got %0d want %0d", per5, PLow1); end
    repeat (2) drive_period(PHigh3);
    rise_peek(PHigh3, n4, n5, s5, v5, per5);
    tests++; if (n4 !== 8'h01) begin fails++; $display("FAIL chg_high3_early: got %h want 01", n4); end
    tests++; if (n5 !== 8'hc0 || v5 !== 1'b1) begin fails++; $display("FAIL chg_high3: got %h/%b want c0/1", n5, v5); end
    tests++; if (per5 !== 18'(PHigh3)) begin fails++; $display("FAIL chg_high3_period: got %0d want %0d", per5, PHigh3); end
    tests++; if (stb_total - base !== 4) begin fails++; $display("FAIL chg_stb_count: got %0d want 4", stb_total - base); end
  endtask

  // Entered at the negedge PHigh3 cycles after the last rise; the note clears on edge 2+Timeout.
  task automatic test_silence();
    repeat (Timeout + 2 - PHigh3) @(negedge clk);
    tests++; if (note !== 8'hc0) begin fails++; $display("FAIL sil_before: got %h want c0", note); end
    @(negedge clk);
    tests++; if (note !== 8'h00 || note_valid !== 1'b0) begin fails++; $display("FAIL sil_note: got %h/%b want 00/0", note, note_valid); end
    tests++; if (note_stb !== 1'b1) begin fails++; $display("FAIL sil_stb: got %b want 1", note_stb); end
    @(negedge clk);
    tests++; if (note_stb !== 1'b0) begin fails++; $display("FAIL sil_stb_end: got %b want 0", note_stb); end
    tests++; if (period !== 18'(PHigh3)) begin fails++; $display("FAIL sil_period: got %0d want %0d", period, PHigh3); end
  endtask

  task automatic test_timeout_rise();
    logic [7:0] n4, n5;
    logic s5, v5;
    logic [17:0] per5;
    int base;
    base = stb_total;
    drive_period(Timeout);
    rise_peek(PHigh3, n4, n5, s5, v5, per5);
    tests++; if (per5 !== 18'(Timeout)) begin fails++; $display("FAIL tor_period: got %0d want %0d", per5, Timeout); end
    tests++; if (n5 !== 8'h00 || s5 !== 1'b0) begin fails++; $display("FAIL tor_note: got %h/%b want 00/0", n5, s5); end
    rise_peek(PHigh3, n4, n5, s5, v5, per5);
    tests++; if (per5 !== 18'(PHigh3)) begin fails++; $display("FAIL tor_still_meas: got %0d want %0d", per5, PHigh3); end
    tests++; if (stb_total - base !== 0) begin fails++; $display("FAIL tor_stb_count: got %0d want 0", stb_total - base); end
  endtask

  task automatic test_midrun_reset();
    logic [7:0] n4, n5;
    logic s5, v5;
    logic [17:0] per5;
    repeat (4) drive_period(PDo);
    tests++; if (note !== 8'h08) begin fails++; $display("FAIL mrr_before: got %h want 08", note); end
    tone_in = 1'b1;
    repeat (PDo / 2) @(negedge clk);
    tone_in = 1'b0;
    repeat (100) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tests++; if (note !== 8'h00 || note_valid !== 1'b0) begin fails++; $display("FAIL mrr_note: got %h/%b want 00/0", note, note_valid); end
    tests++; if (note_stb !== 1'b0) begin fails++; $display("FAIL mrr_stb: got %b want 0", note_stb); end
    tests++; if (period !== 18'd0) begin fails++; $display("FAIL mrr_period: got %0d want 0", period); end
    tests++; if (com !== 4'h7) begin fails++; $display("FAIL mrr_com: got %h want 7", com); end
    repeat (PDo - PDo / 2 - 101) @(negedge clk);
    drive_period(PDo);
    tests++; if (period !== 18'd0) begin fails++; $display("FAIL mrr_first_rise: got %0d want 0", period); end
    repeat (2) drive_period(PDo);
    rise_peek(PDo, n4, n5, s5, v5, per5);
    tests++; if (n4 !== 8'h00) begin fails++; $display("FAIL mrr_early: got %h want 00", n4); end
    tests++; if (n5 !== 8'h08 || s5 !== 1'b1) begin fails++; $display("FAIL mrr_back: got %h/%b want 08/1", n5, s5); end
    tests++; if (per5 !== 18'(PDo)) begin fails++; $display("FAIL mrr_back_period: got %0d want %0d", per5, PDo); end
  endtask

  initial begin
    test_reset();
    test_mid_do();
    test_display();
    test_tolerance();
    test_note_change();
    test_silence();
    test_timeout_rise();
    test_midrun_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
